// File: rtl/rv_hazard_pkg.sv
// Shared types and constants for the RV32 hazard/forwarding controller.
//   hz_entry_t : one in-flight destination record {valid, rd, we, is_load}
//   hz_ex_t    : E-stage record, adds the source operands EX will read
//   FWD_REGFILE: forward select value meaning "use the register file"
//   fwd_w()    : forward select value that picks the W stage
// rd/rs fields are sized to HZ_AW_MAX and zero-extended from REG_AW.
package rv_hazard_pkg;
  localparam int HZ_AW_MAX   = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                 valid;
    logic [HZ_AW_MAX-1:0] rd;
    logic                 we;
    logic                 is_load;
  } hz_entry_t;

  typedef struct packed {
    hz_entry_t            ent;
    logic [HZ_AW_MAX-1:0] rs1;
    logic [HZ_AW_MAX-1:0] rs2;
    logic                 use1;
    logic                 use2;
  } hz_ex_t;

  function automatic int fwd_w(input int mem_stages);
    return mem_stages + 1;
  endfunction
endpackage

// File: rtl/rv_hz_stage_tracker.sv
// Shadow of the E, M1..Mn, W pipeline registers as seen by the hazard logic.
//   clk, reset (sync, active-low) : clock / clear all entries
//   hold                          : freeze every entry
//   flush_e                       : load a bubble into E instead of d
//   d                             : decoded D-stage info (already valid-qualified)
//   ex, mem[1..n], wb             : current shadow contents
module rv_hz_stage_tracker
  import rv_hazard_pkg::*;
#(
  parameter int MEM_STAGES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hold,
  input  logic                         flush_e,
  input  hz_ex_t                       d,
  output hz_ex_t                       ex,
  output hz_entry_t [MEM_STAGES:1]     mem,
  output hz_entry_t                    wb
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else if (!hold) begin
      wb <= mem[MEM_STAGES];
      for (int k = MEM_STAGES; k > 1; k--) mem[k] <= mem[k-1];
      mem[1] <= ex.ent;
      ex     <= flush_e ? '0 : d;
    end
  end

endmodule

// File: rtl/rv_hazard_scoreboard.sv
// Hazard / forwarding controller for the in-order RV32 pipe F-D-E-M1..Mn-W.
// MEM_STAGES=1 behaves like the classic 5-stage hazard unit.
//   clk, reset (sync, active-low)
//   id_*        : D-stage instruction info
//   ex_redirect : taken branch/jump resolved in E
//   mem_hold    : data memory not ready, freeze the pipe
//   stall_f/stall_d/flush_d/flush_e/hold : front-end and pipe control
//   fwd_a_e/fwd_b_e : EX operand select (0 regfile, k = Mk, MEM_STAGES+1 = W)
//   perf_stall/perf_flush : saturating counters, present only when
//                           HZ_PERF_CNT_EN is defined (else tied to 0)
module rv_hazard_scoreboard
  import rv_hazard_pkg::*;
#(
  parameter  int MEM_STAGES = 1,
  parameter  int REG_AW     = 5,
  parameter  int CNT_W      = 32,
  localparam int FW         = $clog2(MEM_STAGES + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  input  logic              mem_hold,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              hold,
  output logic [FW-1:0]     fwd_a_e,
  output logic [FW-1:0]     fwd_b_e,
  output logic [CNT_W-1:0]  perf_stall,
  output logic [CNT_W-1:0]  perf_flush
);

  hz_ex_t                   d_info, ex;
  hz_entry_t [MEM_STAGES:1] mem;
  hz_entry_t                wb;
  logic                     loaduse;

  always_comb begin
    d_info             = '0;
    d_info.ent.valid   = id_valid;
    d_info.ent.rd      = HZ_AW_MAX'(id_rd);
    d_info.ent.we      = id_regwrite;
    d_info.ent.is_load = id_is_load;
    d_info.rs1         = HZ_AW_MAX'(id_rs1);
    d_info.rs2         = HZ_AW_MAX'(id_rs2);
    d_info.use1        = id_valid & id_use_rs1;
    d_info.use2        = id_valid & id_use_rs2;
  end

  rv_hz_stage_tracker #(.MEM_STAGES(MEM_STAGES)) u_trk (
    .clk     (clk),
    .reset   (reset),
    .hold    (hold),
    .flush_e (flush_e),
    .d       (d_info),
    .ex      (ex),
    .mem     (mem),
    .wb      (wb)
  );

  // W-stage load flag is not needed: W data is final regardless of source.
  logic unused_wb_load;
  assign unused_wb_load = wb.is_load;

  // A load still in E or M1..M(n-1) has no data yet for a D consumer.
  function automatic logic ld_hit(input logic use_s, input logic [HZ_AW_MAX-1:0] s,
                                  input hz_entry_t e);
    return use_s && (s != '0) && e.valid && e.we && e.is_load && (e.rd == s);
  endfunction

  always_comb begin
    loaduse = ld_hit(d_info.use1, d_info.rs1, ex.ent) |
              ld_hit(d_info.use2, d_info.rs2, ex.ent);
    for (int k = 1; k < MEM_STAGES; k++)
      loaduse = loaduse | ld_hit(d_info.use1, d_info.rs1, mem[k]) |
                          ld_hit(d_info.use2, d_info.rs2, mem[k]);
  end

  // Scan oldest to youngest so the youngest producer overwrites older ones.
  // Loads in M are skipped: the stall logic keeps them away from E consumers.
  function automatic logic [FW-1:0] fwd_sel(input logic use_s, input logic [HZ_AW_MAX-1:0] s,
                                            input hz_entry_t [MEM_STAGES:1] m,
                                            input hz_entry_t w);
    logic [FW-1:0] sel;
    sel = FW'(FWD_REGFILE);
    if (use_s && (s != '0)) begin
      if (w.valid && w.we && (w.rd == s)) sel = FW'(fwd_w(MEM_STAGES));
      for (int k = MEM_STAGES; k >= 1; k--)
        if (m[k].valid && m[k].we && !m[k].is_load && (m[k].rd == s)) sel = FW'(k);
    end
    return sel;
  endfunction

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    hold    = 1'b0;
    fwd_a_e = FW'(FWD_REGFILE);
    fwd_b_e = FW'(FWD_REGFILE);
    if (!reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      fwd_a_e = fwd_sel(ex.use1, ex.rs1, mem, wb);
      fwd_b_e = fwd_sel(ex.use2, ex.rs2, mem, wb);
      if (mem_hold) begin
        // Redirect stays in the frozen E stage and is seen again later.
        hold    = 1'b1;
        stall_f = 1'b1;
        stall_d = 1'b1;
      end else if (ex_redirect) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (loaduse) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && (stall_cnt != '1))                flush_cnt <= flush_cnt;
      if (stall_d && (stall_cnt != '1))                stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_d && ex_redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign perf_stall = stall_cnt;
  assign perf_flush = flush_cnt;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_rv_hazard_scoreboard.sv
// Directed bench for rv_hazard_scoreboard. Two instances (MEM_STAGES=1 and 2)
// share the same stimulus; each step names the instance whose outputs are
// checked. Expected outputs are queued when stimulus is applied and popped
// and compared at the following negedge.
module tb_rv_hazard_scoreboard;
`ifdef HZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
  logic       ex_redirect, mem_hold;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        sf1, sd1, fd1, fe1, h1, sf2, sd2, fd2, fe2, h2;
  logic [1:0]  fa1, fb1, fa2, fb2;
  logic [31:0] ps1, pf1, ps2, pf2;

  rv_hazard_scoreboard #(.MEM_STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_hold(mem_hold), .stall_f(sf1), .stall_d(sd1), .flush_d(fd1), .flush_e(fe1),
    .hold(h1), .fwd_a_e(fa1), .fwd_b_e(fb1), .perf_stall(ps1), .perf_flush(pf1));

  rv_hazard_scoreboard #(.MEM_STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_hold(mem_hold), .stall_f(sf2), .stall_d(sd2), .flush_d(fd2), .flush_e(fe2),
    .hold(h2), .fwd_a_e(fa2), .fwd_b_e(fb2), .perf_stall(ps2), .perf_flush(pf2));

  // ctl = {stall_f, stall_d, flush_d, flush_e, hold}; ps/pf < 0 means unchecked
  typedef struct {
    int         dut;
    string      tag;
    logic [4:0] ctl;
    int         fa, fb, ps, pf;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, rs2, input logic u1, u2,
                     input logic [4:0] rd, input logic we, ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = we; id_is_load = ld;
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Called at posedge+1 with inputs already applied; returns at next posedge+1.
  task automatic step(input int dut, input string tag, input logic [4:0] ctl,
                      input int fa, input int fb, input int ps = -1, input int pf = -1);
    exp_t e;
    logic [4:0]  g_ctl;
    logic [1:0]  g_fa, g_fb;
    logic [31:0] g_ps, g_pf;
    e.dut = dut; e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb;
    e.ps = (ps < 0) ? -1 : (PERF ? ps : 0);
    e.pf = (pf < 0) ? -1 : (PERF ? pf : 0);
    sbq.push_back(e);
    @(negedge clk);
    e = sbq.pop_front();
    if (e.dut == 1) begin
      g_ctl = {sf1, sd1, fd1, fe1, h1}; g_fa = fa1; g_fb = fb1; g_ps = ps1; g_pf = pf1;
    end else begin
      g_ctl = {sf2, sd2, fd2, fe2, h2}; g_fa = fa2; g_fb = fb2; g_ps = ps2; g_pf = pf2;
    end
    chk({e.tag, ".ctl"}, 32'(g_ctl), 32'(e.ctl));
    chk({e.tag, ".fwd_a"}, 32'(g_fa), e.fa);
    chk({e.tag, ".fwd_b"}, 32'(g_fb), e.fb);
    if (e.ps >= 0) chk({e.tag, ".perf_stall"}, g_ps, e.ps);
    if (e.pf >= 0) chk({e.tag, ".perf_flush"}, g_pf, e.pf);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int dut, input string tag);
    reset = 1'b0; ex_redirect = 1'b0; mem_hold = 1'b0; nop();
    step(dut, tag, 5'b00110, 0, 0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; ex_redirect = 1'b0; mem_hold = 1'b0; nop();
    @(posedge clk); #1;

    // A: N=1 load-use, one stall, then forward from W (code 2)
    do_reset(1, "rstA");
    drv(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  step(1, "A0", 5'b00000, 0, 0, 0, 0);
    drv(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);  step(1, "A1", 5'b11010, 0, 0);
    step(1, "A2", 5'b00000, 0, 0);
    nop();                                 step(1, "A3", 5'b00000, 2, 0, 1, 0);

    // B: N=2 load-use, two stalls, then forward from W (code 3)
    do_reset(2, "rstB");
    drv(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  step(2, "B0", 5'b00000, 0, 0);
    drv(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);  step(2, "B1", 5'b11010, 0, 0);
    step(2, "B2", 5'b11010, 0, 0);
    step(2, "B3", 5'b00000, 0, 0);
    nop();                                 step(2, "B4", 5'b00000, 3, 0, 2, 0);

    // C: x5 in both M1 and W -> youngest (M1) wins; rs2=x0 -> regfile
    do_reset(1, "rstC");
    drv(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0);  step(1, "C0", 5'b00000, 0, 0);
    step(1, "C1", 5'b00000, 0, 0);
    drv(1, 5'd5, 5'd0, 1, 1, 5'd7, 1, 0);  step(1, "C2", 5'b00000, 0, 0);
    nop();                                 step(1, "C3", 5'b00000, 1, 0);
    step(1, "C4", 5'b00000, 0, 0);

    // D: redirect overrides a coincident load-use
    do_reset(1, "rstD");
    drv(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  step(1, "D0", 5'b00000, 0, 0);
    drv(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);
    ex_redirect = 1'b1;                    step(1, "D1", 5'b00110, 0, 0);
    ex_redirect = 1'b0; nop();             step(1, "D2", 5'b00000, 0, 0, 0, 1);

    // E: 3 cycles of mem_hold with pending redirect, shadow frozen throughout
    do_reset(1, "rstE");
    drv(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0);  step(1, "E0", 5'b00000, 0, 0);
    drv(1, 5'd5, 5'd0, 1, 0, 5'd7, 1, 0);  step(1, "E1", 5'b00000, 0, 0);
    nop(); mem_hold = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) step(1, $sformatf("E%0d", i + 2), 5'b11001, 1, 0);
    mem_hold = 1'b0;                       step(1, "E5", 5'b00110, 1, 0);
    ex_redirect = 1'b0;                    step(1, "E6", 5'b00000, 0, 0, 3, 1);

    // F: N=2 reset while load in M1, then a load to x0 is never a hazard
    do_reset(2, "rstF");
    drv(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  step(2, "F0", 5'b00000, 0, 0);
    drv(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);  step(2, "F1", 5'b11010, 0, 0);
    reset = 1'b0;                          step(2, "F2", 5'b00110, 0, 0);
    reset = 1'b1;                          step(2, "F3", 5'b00000, 0, 0, 0, 0);
    drv(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1);  step(2, "F4", 5'b00000, 0, 0);
    drv(1, 5'd0, 5'd0, 1, 1, 5'd8, 1, 0);  step(2, "F5", 5'b00000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
